// File: rtl/restoring_divider.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
// A division runs for N step cycles plus one closing cycle, then shows a
// one-cycle done pulse; results hold until the next accepted start.
// Optional build macro: DIVIDER_ZERO_DETECT_EN -- a zero divisor skips the
// iterative loop and reports div_zero=1 one cycle after the start edge.
module restoring_divider #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   q_reg, rem_reg, dvs_reg;
  logic [N-1:0]   quotient_reg, remainder_reg;
  logic [CW-1:0]  cnt_reg;
  logic [N:0]     shifted, trial;
  logic           accept, zero_bypass, zero_pend, finish;

  // While a zero-divisor shortcut is pending the FSM sits in IDLE for one
  // cycle; a start in that cycle is not taken so the pending result wins.
  assign accept  = start && (((state_reg == IDLE) && !zero_pend) || (state_reg == DONE));
  assign finish  = (state_reg == RUN) && (cnt_reg == '0);

  // The partial remainder stays below the divisor, so the N+1-bit trial
  // never overflows and its top bit is a true sign bit.
  assign shifted = {rem_reg, q_reg[N-1]};
  assign trial   = shifted - {1'b0, dvs_reg};

`ifdef DIVIDER_ZERO_DETECT_EN
  logic zero_pend_reg, div_zero_reg;

  assign zero_bypass = (divisor == '0);
  assign zero_pend   = zero_pend_reg;
  assign div_zero    = div_zero_reg;

  // Remember a zero-divisor start for one cycle, then flag it with the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_pend_reg <= 1'b0;
      div_zero_reg  <= 1'b0;
    end else begin
      zero_pend_reg <= accept && zero_bypass;
      if (zero_pend_reg)
        div_zero_reg <= 1'b1;
      else if (finish)
        div_zero_reg <= 1'b0;
    end
  end
`else
  assign zero_bypass = 1'b0;
  assign zero_pend   = 1'b0;
  assign div_zero    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic: DONE can chain straight into a new RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (zero_pend)
          state_next = DONE;
        else if (accept)
          state_next = zero_bypass ? IDLE : RUN;
      end
      RUN: begin
        if (cnt_reg == '0)
          state_next = DONE;
      end
      DONE: begin
        if (accept)
          state_next = zero_bypass ? IDLE : RUN;
        else
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, restoring iteration and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_reg         <= '0;
      rem_reg       <= '0;
      dvs_reg       <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      if (accept) begin
        q_reg   <= dividend;
        dvs_reg <= divisor;
        rem_reg <= '0;
        cnt_reg <= CW'(N);
      end else if ((state_reg == RUN) && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - CW'(1);
        if (!trial[N]) begin
          rem_reg <= trial[N-1:0];
          q_reg   <= {q_reg[N-2:0], 1'b1};
        end else begin
          rem_reg <= shifted[N-1:0];
          q_reg   <= {q_reg[N-2:0], 1'b0};
        end
      end

      if (finish) begin
        quotient_reg  <= q_reg;
        remainder_reg <= rem_reg;
      end else if (zero_pend) begin
        // q_reg still holds the untouched dividend here.
        quotient_reg  <= '1;
        remainder_reg <= q_reg;
      end
    end
  end

  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider (N=16): stimulus pushes expected
// results with their expected done cycle, a monitor checks each done pulse.
module tb_restoring_divider;
  localparam int N = 16;

`ifdef DIVIDER_ZERO_DETECT_EN
  localparam int   ZLAT  = 1;
  localparam logic ZFLAG = 1'b1;
`else
  localparam int   ZLAT  = 17;
  localparam logic ZFLAG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, div_zero;
  logic [N-1:0] quotient, remainder;

  restoring_divider #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           at;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check({e.name, " quotient"}, 32'(quotient), 32'(e.q));
        check({e.name, " remainder"}, 32'(remainder), 32'(e.r));
        check({e.name, " div_zero"}, 32'(div_zero), 32'(e.dz));
        check({e.name, " done_cycle"}, cyc, e.at);
        $display("txn %s: q=%0d r=%0d dz=%0b cycle=%0d", e.name, quotient, remainder, div_zero, cyc);
      end
    end
  end

  // Present start for one edge; optionally record the expected result.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eq, input logic [N-1:0] er,
                       input logic edz, input int lat, input bit push, input string name);
    exp_t e;
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.q = eq; e.r = er; e.dz = edz; e.at = cyc + lat; e.name = name;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
    exp_q.delete();
  endtask

  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic [N-1:0] eq, input logic [N-1:0] er);
    issue(a, b, eq, er, 1'b0, 17, 1'b1, $sformatf("%0d/%0d", a, b));
    wait_drain(40);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [N-1:0] vec_a [6] = '{16'd65535, 16'd0, 16'd12345, 16'd40000, 16'd1, 16'd7};
  logic [N-1:0] vec_b [6] = '{16'd65535, 16'd5, 16'd255,   16'd123,   16'd2, 16'd7};
  logic [N-1:0] vec_q [6] = '{16'd1,     16'd0, 16'd48,    16'd325,   16'd0, 16'd1};
  logic [N-1:0] vec_r [6] = '{16'd0,     16'd0, 16'd105,   16'd25,    16'd1, 16'd0};

  initial begin : stim
    logic [N-1:0] ra, rb;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset div_zero", 32'(div_zero), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic division and result hold
    run(16'd100, 16'd7, 16'd14, 16'd2);
    repeat (3) @(negedge clk);
    check("hold busy", 32'(busy), 32'd0);
    check("hold quotient", 32'(quotient), 32'd14);
    check("hold remainder", 32'(remainder), 32'd2);

    // Back-to-back: second start presented in the DONE cycle
    @(negedge clk);
    issue(16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0, 17, 1'b1, "65535/1");
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    #1;
    issue(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 17, 1'b1, "5/9");
    check("b2b busy_after_done", 32'(busy), 32'd1);
    wait_drain(40);

    // Zero divisor
    issue(16'd1234, 16'd0, 16'hFFFF, 16'd1234, ZFLAG, ZLAT, 1'b1, "1234/0");
    wait_drain(40);

    // Start during RUN is ignored
    issue(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 17, 1'b1, "1000/3");
    repeat (4) @(negedge clk);
    start = 1'b1;
    dividend = 16'd7;
    divisor = 16'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignored_start busy", 32'(busy), 32'd1);
    wait_drain(40);

    // Reset mid-RUN aborts with no done pulse
    issue(16'd200, 16'd9, '0, '0, 1'b0, 17, 1'b0, "abort");
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort quotient", 32'(quotient), 32'd0);
    check("abort remainder", 32'(remainder), 32'd0);
    check("abort div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    run(16'd50, 16'd6, 16'd8, 16'd2);

    // Directed boundary vectors
    for (int i = 0; i < 6; i++) run(vec_a[i], vec_b[i], vec_q[i], vec_r[i]);

    // Short random sweep against the arithmetic identity
    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom);
      rb = (i % 2 == 0) ? N'($urandom_range(1, 15)) : N'($urandom_range(1, 65535));
      run(ra, rb, ra / rb, ra % rb);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
